// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared type and constant definitions for the multi-cycle core's memory
// arbitration logic.
//   arb_state_t : arbiter FSM states (IDLE, MEM, RESP)
//   OWNER_IF    : owner code of the instruction-fetch requester
//   OWNER_D     : owner code of the load/store requester
// ---------------------------------------------------------------------------
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,   // waiting for a request
        MEM  = 2'd1,   // memory transaction outstanding
        RESP = 2'd2    // one-cycle response pulse to the owner
    } arb_state_t;

    localparam logic OWNER_IF = 1'b0;
    localparam logic OWNER_D  = 1'b1;

endpackage

// File: rtl/mem_arb_pick.sv
// ---------------------------------------------------------------------------
// mem_arb_pick
// Combinational winner selection between the fetch and data requesters.
// A lone requester always wins. On a tie the data requester wins, unless
// MEM_ARB_RR_EN is defined, in which case the requester not served last wins.
//
// Build option: MEM_ARB_RR_EN (round-robin tie breaking)
//
// Ports
//   if_req      in  fetch request
//   d_req       in  data request
//   last_served in  owner of the previous grant (only used with MEM_ARB_RR_EN)
//   grant_valid out at least one requester is active
//   grant_owner out winning requester (OWNER_IF / OWNER_D)
// ---------------------------------------------------------------------------
module mem_arb_pick
    import cpu_pkg::*;
(
    input  logic if_req,
    input  logic d_req,
    input  logic last_served,
    output logic grant_valid,
    output logic grant_owner
);

`ifndef MEM_ARB_RR_EN
    // Fixed priority ignores the history input entirely.
    logic unused_last_served_s;
    assign unused_last_served_s = last_served;
`endif

    // Winner selection: single requester wins, tie resolved by build option.
    always_comb begin
        grant_valid = if_req | d_req;
        grant_owner = OWNER_IF;
        if (if_req && d_req) begin
`ifdef MEM_ARB_RR_EN
            grant_owner = (last_served == OWNER_D) ? OWNER_IF : OWNER_D;
`else
            grant_owner = OWNER_D;
`endif
        end else if (d_req) begin
            grant_owner = OWNER_D;
        end else begin
            grant_owner = OWNER_IF;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
// Shares the single unified memory port between the instruction-fetch and
// the load/store requesters. A granted request is latched into the mem_*
// registers, one transaction is driven at a time, and when mem_ready arrives
// a one-cycle registered response is returned to the owner.
//
// Build option: MEM_ARB_RR_EN (round-robin tie breaking; default is fixed
//               priority with data winning ties)
//
// Parameters
//   ADDR_W  address width of all ports
//   DATA_W  data width (byte enables are DATA_W/8 wide)
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-low reset
//   if_req     in   fetch request, held until if_valid
//   if_addr    in   fetch byte address
//   if_rdata   out  fetched word
//   if_valid   out  one-cycle fetch response pulse
//   d_req      in   data request, held until d_valid
//   d_we       in   1 = store, 0 = load
//   d_be       in   store byte enables
//   d_addr     in   data byte address
//   d_wdata    in   store data
//   d_rdata    out  load data (0 on store responses)
//   d_valid    out  one-cycle data response pulse
//   mem_req    out  memory transaction active
//   mem_we     out  registered write enable
//   mem_be     out  registered byte enables
//   mem_addr   out  registered address
//   mem_wdata  out  registered write data
//   mem_rdata  in   memory read data, valid with mem_ready
//   mem_ready  in   transaction complete, only honoured while mem_req=1
//   busy       out  arbiter not idle
//   owner      out  owner of the current/last transaction (0 fetch, 1 data)
// ---------------------------------------------------------------------------
module mem_arbiter
    import cpu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_valid,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [DATA_W/8-1:0] d_be,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_valid,
    output logic                mem_req,
    output logic                mem_we,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_ready,
    output logic                busy,
    output logic                owner
);

    localparam int BE_W = DATA_W / 8;

    arb_state_t          state_r;
    arb_state_t          state_next_s;

    logic                grant_valid_s;
    logic                grant_owner_s;
    logic                last_served_s;
    logic                grant_load_s;
    logic                complete_s;

    logic                mem_req_r;
    logic                busy_r;
    logic                owner_r;
    logic                mem_we_r;
    logic [BE_W-1:0]     mem_be_r;
    logic [ADDR_W-1:0]   mem_addr_r;
    logic [DATA_W-1:0]   mem_wdata_r;
    logic [DATA_W-1:0]   if_rdata_r;
    logic [DATA_W-1:0]   d_rdata_r;
    logic                if_valid_r;
    logic                d_valid_r;

    mem_arb_pick u_pick (
        .if_req      (if_req),
        .d_req       (d_req),
        .last_served (last_served_s),
        .grant_valid (grant_valid_s),
        .grant_owner (grant_owner_s)
    );

`ifdef MEM_ARB_RR_EN
    logic last_served_r;

    // History of the most recent grant, used only to break ties.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_served_r <= OWNER_IF;
        end else if (grant_load_s) begin
            last_served_r <= grant_owner_s;
        end
    end

    assign last_served_s = last_served_r;
`else
    assign last_served_s = OWNER_IF;
`endif

    // FSM state register; mem_req and busy are registered copies of the
    // next state so they change together with it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r   <= IDLE;
            mem_req_r <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            mem_req_r <= (state_next_s == MEM);
            busy_r    <= (state_next_s != IDLE);
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (grant_valid_s) begin
                    state_next_s = MEM;
                end else begin
                    state_next_s = IDLE;
                end
            end
            MEM: begin
                if (mem_ready) begin
                    state_next_s = RESP;
                end else begin
                    state_next_s = MEM;
                end
            end
            RESP:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // FSM control strobes: grant in IDLE, completion in MEM. mem_ready in
    // any other state is ignored here.
    always_comb begin
        grant_load_s = 1'b0;
        complete_s   = 1'b0;
        case (state_r)
            IDLE: begin
                grant_load_s = grant_valid_s;
            end
            MEM: begin
                complete_s = mem_ready;
            end
            RESP: begin
                grant_load_s = 1'b0;
            end
            default: begin
                grant_load_s = 1'b0;
                complete_s   = 1'b0;
            end
        endcase
    end

    // Transaction attribute latch; fetches are forced to full-word reads.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner_r     <= OWNER_IF;
            mem_we_r    <= 1'b0;
            mem_be_r    <= {BE_W{1'b0}};
            mem_addr_r  <= {ADDR_W{1'b0}};
            mem_wdata_r <= {DATA_W{1'b0}};
        end else if (grant_load_s) begin
            owner_r <= grant_owner_s;
            if (grant_owner_s == OWNER_D) begin
                mem_we_r    <= d_we;
                mem_be_r    <= d_be;
                mem_addr_r  <= d_addr;
                mem_wdata_r <= d_wdata;
            end else begin
                mem_we_r    <= 1'b0;
                mem_be_r    <= {BE_W{1'b1}};
                mem_addr_r  <= if_addr;
                mem_wdata_r <= {DATA_W{1'b0}};
            end
        end
    end

    // Response registers; the non-owner's read data keeps its old value.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            if_valid_r <= 1'b0;
            d_valid_r  <= 1'b0;
            if_rdata_r <= {DATA_W{1'b0}};
            d_rdata_r  <= {DATA_W{1'b0}};
        end else begin
            if_valid_r <= complete_s && (owner_r == OWNER_IF);
            d_valid_r  <= complete_s && (owner_r == OWNER_D);
            if (complete_s && (owner_r == OWNER_IF)) begin
                if_rdata_r <= mem_rdata;
            end
            if (complete_s && (owner_r == OWNER_D)) begin
                d_rdata_r <= mem_we_r ? {DATA_W{1'b0}} : mem_rdata;
            end
        end
    end

    assign mem_req   = mem_req_r;
    assign busy      = busy_r;
    assign owner     = owner_r;
    assign mem_we    = mem_we_r;
    assign mem_be    = mem_be_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign if_rdata  = if_rdata_r;
    assign if_valid  = if_valid_r;
    assign d_rdata   = d_rdata_r;
    assign d_valid   = d_valid_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
// Self-checking bench for mem_arbiter. Directed scenarios followed by a
// randomized run; expectations come from a transaction-level model that
// tracks the tie-break history and each requester's last returned data.
// Honours MEM_ARB_RR_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

    logic        clk;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_valid;
    logic        d_req;
    logic        d_we;
    logic [3:0]  d_be;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_valid;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        busy;
    logic        owner;

    int tests_run;
    int fail_cnt;

    // Reference model state
    logic        last_m;     // last served requester (1 = data)
    logic [31:0] ex_if_m;    // expected if_rdata
    logic [31:0] ex_d_m;     // expected d_rdata

    mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_valid  (if_valid),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_be      (d_be),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_valid   (d_valid),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_be    (mem_be),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .busy      (busy),
        .owner     (owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Winner per the arbitration rules: lone requester wins; tie goes to
    // data, or with round-robin to whoever was not served last.
    function automatic logic model_pick(input logic fr, input logic dr);
        if (fr && dr) begin
`ifdef MEM_ARB_RR_EN
            return last_m ? 1'b0 : 1'b1;
`else
            return 1'b1;
`endif
        end
        return dr;
    endfunction

    task automatic chk_reset_values(input string tag);
        chk({tag, "_mem_req"}, 32'(mem_req), 32'd0);
        chk({tag, "_busy"},    32'(busy), 32'd0);
        chk({tag, "_owner"},   32'(owner), 32'd0);
        chk({tag, "_valids"},  32'({if_valid, d_valid}), 32'd0);
        chk({tag, "_mem_we"},  32'(mem_we), 32'd0);
        chk({tag, "_mem_be"},  32'(mem_be), 32'd0);
        chk({tag, "_mem_addr"}, mem_addr, 32'd0);
        chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
        chk({tag, "_if_rdata"}, if_rdata, 32'd0);
        chk({tag, "_d_rdata"},  d_rdata, 32'd0);
    endtask

    // One full transaction starting from an IDLE cycle with the requests
    // already driven. Ends in the IDLE cycle after the response pulse.
    task automatic run_txn(input int delay, input logic [31:0] rd, input bit scramble,
                           input bit rdy_in_resp, output logic own);
        logic        e_we;
        logic [3:0]  e_be;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_mem_req", 32'(mem_req), 32'd0);
        own = model_pick(if_req, d_req);
        if (own) begin
            e_we = d_we; e_be = d_be; e_addr = d_addr; e_wdata = d_wdata;
        end else begin
            e_we = 1'b0; e_be = 4'hF; e_addr = if_addr; e_wdata = 32'd0;
        end
        mem_ready = 1'b0;
        step();
        for (int i = 0; i <= delay; i++) begin
            chk("mem_req", 32'(mem_req), 32'd1);
            chk("busy", 32'(busy), 32'd1);
            chk("owner", 32'(owner), 32'(own));
            chk("mem_we", 32'(mem_we), 32'(e_we));
            chk("mem_be", 32'(mem_be), 32'(e_be));
            chk("mem_addr", mem_addr, e_addr);
            chk("mem_wdata", mem_wdata, e_wdata);
            chk("mem_no_valid", 32'({if_valid, d_valid}), 32'd0);
            if (scramble) begin
                if (own) begin
                    d_addr  = d_addr ^ 32'h0000_0300;
                    d_wdata = ~d_wdata;
                    d_be    = ~d_be;
                    d_we    = ~d_we;
                end else begin
                    if_addr = if_addr ^ 32'h0000_0300;
                end
            end
            mem_ready = (i == delay);
            mem_rdata = (i == delay) ? rd : $urandom;
            step();
        end
        if (own) ex_d_m = e_we ? 32'd0 : rd;
        else     ex_if_m = rd;
        last_m = own;
        chk("if_valid", 32'(if_valid), 32'(!own));
        chk("d_valid", 32'(d_valid), 32'(own));
        chk("if_rdata", if_rdata, ex_if_m);
        chk("d_rdata", d_rdata, ex_d_m);
        chk("resp_busy", 32'(busy), 32'd1);
        chk("resp_mem_req", 32'(mem_req), 32'd0);
        mem_ready = rdy_in_resp;
        mem_rdata = $urandom;
        step();
        chk("post_valids", 32'({if_valid, d_valid}), 32'd0);
        chk("post_busy", 32'(busy), 32'd0);
        chk("post_if_rdata", if_rdata, ex_if_m);
        chk("post_d_rdata", d_rdata, ex_d_m);
        mem_ready = 1'b0;
    endtask

    initial begin
        logic own;
        tests_run = 0;
        fail_cnt  = 0;
        last_m    = 1'b0;
        ex_if_m   = 32'd0;
        ex_d_m    = 32'd0;
        reset     = 1'b0;
        if_req    = 1'b0; if_addr = 32'd0;
        d_req     = 1'b0; d_we = 1'b0; d_be = 4'd0; d_addr = 32'd0; d_wdata = 32'd0;
        mem_rdata = 32'd0; mem_ready = 1'b0;

        // Reset state
        step(); step();
        chk_reset_values("rst");
        reset = 1'b1;
        step();
        chk_reset_values("rst_rel");

        // Fetch only
        if_req = 1'b1; if_addr = 32'h10;
        run_txn(0, 32'hDEADBEEF, 1'b0, 1'b0, own);
        chk("fetch_owner", 32'(own), 32'd0);
        if_req = 1'b0;

        // Store, slow memory, attributes changed during MEM
        d_req = 1'b1; d_we = 1'b1; d_be = 4'h3; d_addr = 32'h100; d_wdata = 32'h12345678;
        run_txn(4, 32'hFFFF_FFFF, 1'b1, 1'b1, own);
        d_req = 1'b0;

        // Load so that d_rdata and owner are non-zero before the reset test
        d_req = 1'b1; d_we = 1'b0; d_be = 4'h0; d_addr = 32'h204; d_wdata = 32'h0;
        run_txn(1, 32'hCAFEF00D, 1'b0, 1'b0, own);
        d_req = 1'b0;

        // Reset in MEM with mem_ready pending
        d_req = 1'b1; d_we = 1'b1; d_be = 4'hF; d_addr = 32'h300; d_wdata = 32'h55AA55AA;
        step();
        chk("pre_rst_mem_req", 32'(mem_req), 32'd1);
        mem_ready = 1'b1; mem_rdata = 32'h0BAD0BAD;
        #2;
        reset = 1'b0;
        #1;
        chk_reset_values("async_rst");
        d_req = 1'b0;
        last_m = 1'b0; ex_if_m = 32'd0; ex_d_m = 32'd0;
        step();
        reset = 1'b1;
        step();
        chk("spur_rdy_valids", 32'({if_valid, d_valid}), 32'd0);
        chk("spur_rdy_busy", 32'(busy), 32'd0);
        step();
        chk("spur_rdy_valids2", 32'({if_valid, d_valid}), 32'd0);
        chk("spur_rdy_mem_req", 32'(mem_req), 32'd0);
        mem_ready = 1'b0;

        // Ties, three back-to-back pairs, then drain the pending fetch
        if_req = 1'b1; if_addr = 32'h40;
        d_req = 1'b1; d_we = 1'b0; d_be = 4'h0; d_addr = 32'h80; d_wdata = 32'h0;
        for (int k = 0; k < 3; k++) begin
            run_txn(0, 32'h1000 + 32'(k), 1'b0, 1'b0, own);
        end
        d_req = 1'b0;
        run_txn(0, 32'h2000, 1'b0, 1'b0, own);
        chk("drain_owner", 32'(own), 32'd0);
        if_req = 1'b0;

        // Randomized traffic; a losing requester stays pending and unchanged
        for (int t = 0; t < 80; t++) begin
            if (!if_req && ($urandom_range(0, 1) == 1)) begin
                if_req = 1'b1; if_addr = $urandom;
            end
            if (!d_req && ($urandom_range(0, 1) == 1)) begin
                d_req = 1'b1; d_we = 1'($urandom_range(0, 1)); d_be = 4'($urandom);
                d_addr = $urandom; d_wdata = $urandom;
            end
            if (!if_req && !d_req) begin
                mem_ready = 1'($urandom_range(0, 1));
                mem_rdata = $urandom;
                step();
                chk("idle_rdy_valids", 32'({if_valid, d_valid}), 32'd0);
                chk("idle_rdy_busy", 32'(busy), 32'd0);
                mem_ready = 1'b0;
            end else begin
                run_txn($urandom_range(0, 3), $urandom, 1'($urandom_range(0, 1)),
                        1'($urandom_range(0, 1)), own);
                if (own) d_req = 1'b0;
                else     if_req = 1'b0;
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
        $finish;
    end

endmodule
